// File: rtl/alarm_buzzer.sv
// Alarm buzzer sequencer: rings on a rising alarm match, supports a bounded
// number of snoozes, times out after RING_SECS seconds of ringing.
module alarm_buzzer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sec_tick,
    input  logic       buzz_in,
    input  logic       alarmon,
    input  logic       snooze,
    input  logic       stop,
    output logic       buzzer,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt,
    output logic [8:0] sec_cnt
);

    // Legal parameter range: RING_SECS <= 511, 1 <= SNOOZE_SECS <= 511,
    // MAX_SNOOZE <= 3 (snooze_cnt is two bits wide).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_BAD     = 2'd3
    } state_e;

    localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS);
    localparam logic [8:0] CNT_MAX     = 9'h1FF;

    state_e     state_q;
    logic       buzzer_q;
    logic [1:0] snooze_cnt_q;
    logic [8:0] sec_cnt_q;
    logic       buzz_d_q;

    logic start;
    logic snooze_ok;

    // Only the rising edge of the match level starts an event.
    assign start     = buzz_in & ~buzz_d_q;
    assign snooze_ok = int'(snooze_cnt_q) < MAX_SNOOZE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            buzzer_q     <= 1'b0;
            snooze_cnt_q <= 2'd0;
            sec_cnt_q    <= 9'd0;
            buzz_d_q     <= 1'b0;
        end else begin
            buzz_d_q <= buzz_in;
            if (!alarmon) begin
                state_q      <= ST_IDLE;
                buzzer_q     <= 1'b0;
                snooze_cnt_q <= 2'd0;
                sec_cnt_q    <= 9'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        buzzer_q  <= 1'b0;
                        sec_cnt_q <= 9'd0;
                        if (start) begin
                            state_q      <= ST_RINGING;
                            snooze_cnt_q <= 2'd0;
                            buzzer_q     <= 1'b1;
                        end
                    end
                    ST_RINGING: begin
                        if (stop) begin
                            state_q      <= ST_IDLE;
                            buzzer_q     <= 1'b0;
                            snooze_cnt_q <= 2'd0;
                            sec_cnt_q    <= 9'd0;
                        end else if (snooze && snooze_ok) begin
                            state_q      <= ST_SNOOZE;
                            buzzer_q     <= 1'b0;
                            snooze_cnt_q <= snooze_cnt_q + 2'd1;
                            sec_cnt_q    <= SNOOZE_LOAD;
                        end else if (sec_tick) begin
                            if (sec_cnt_q == RING_LAST) begin
                                state_q      <= ST_IDLE;
                                buzzer_q     <= 1'b0;
                                snooze_cnt_q <= 2'd0;
                                sec_cnt_q    <= 9'd0;
                            end else begin
                                // Saturate rather than wrap past 511.
                                if (sec_cnt_q != CNT_MAX) begin
                                    sec_cnt_q <= sec_cnt_q + 9'd1;
                                end
                                buzzer_q <= ~buzzer_q;
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        if (stop) begin
                            state_q      <= ST_IDLE;
                            buzzer_q     <= 1'b0;
                            snooze_cnt_q <= 2'd0;
                            sec_cnt_q    <= 9'd0;
                        end else if (sec_tick) begin
                            // A count of 0 is treated as expired so it cannot underflow.
                            if (sec_cnt_q <= 9'd1) begin
                                state_q   <= ST_RINGING;
                                sec_cnt_q <= 9'd0;
                                buzzer_q  <= 1'b1;
                            end else begin
                                sec_cnt_q <= sec_cnt_q - 9'd1;
                            end
                        end
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        buzzer_q     <= 1'b0;
                        snooze_cnt_q <= 2'd0;
                        sec_cnt_q    <= 9'd0;
                    end
                endcase
            end
        end
    end

    assign buzzer     = buzzer_q;
    assign state      = state_q;
    assign snooze_cnt = snooze_cnt_q;
    assign sec_cnt    = sec_cnt_q;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Testbench for alarm_buzzer: directed scenarios plus random traffic, checked
// cycle by cycle against a second-count model of the alarm behaviour.
module tb_alarm_buzzer;

    localparam int RING   = 60;
    localparam int SNZ    = 300;
    localparam int MAXSNZ = 3;

    logic       clk;
    logic       reset_n;
    logic       sec_tick;
    logic       buzz_in;
    logic       alarmon;
    logic       snooze;
    logic       stop;
    logic       buzzer;
    logic [1:0] state;
    logic [1:0] snooze_cnt;
    logic [8:0] sec_cnt;

    alarm_buzzer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sec_tick   (sec_tick),
        .buzz_in    (buzz_in),
        .alarmon    (alarmon),
        .snooze     (snooze),
        .stop       (stop),
        .buzzer     (buzzer),
        .state      (state),
        .snooze_cnt (snooze_cnt),
        .sec_cnt    (sec_cnt)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_bad    = 0;
    int toggles  = 0;
    logic last_buzz = 1'b0;
    logic on_v = 1'b1;
    logic buzz_v = 1'b0;

    logic [13:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: mode 0 idle, 1 ringing (seconds rung so far), 2 snoozing (seconds left).
    int m_mode, m_elapsed, m_remain, m_snoozes;
    logic m_prev;

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_remain = 0; m_snoozes = 0; m_prev = 1'b0;
    endtask

    task automatic model_idle();
        m_mode = 0; m_elapsed = 0; m_remain = 0; m_snoozes = 0;
    endtask

    task automatic model_step(input logic a, input logic s, input logic p, input logic t, input logic b);
        logic rise;
        rise = b && !m_prev;
        m_prev = b;
        if (!a) model_idle();
        else if (m_mode == 0) begin
            if (rise) begin m_mode = 1; m_elapsed = 0; m_snoozes = 0; end
        end else if (p) model_idle();
        else if (m_mode == 1) begin
            if (s && m_snoozes < MAXSNZ) begin
                m_mode = 2; m_remain = SNZ; m_snoozes++;
            end else if (t) begin
                if (m_elapsed + 1 >= RING) model_idle();
                else m_elapsed++;
            end
        end else if (t) begin
            if (m_remain == 1) begin m_mode = 1; m_elapsed = 0; end
            else m_remain--;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [1:0] st;
        logic [1:0] sc;
        logic [8:0] cnt;
        logic bz;
        st  = 2'(m_mode);
        sc  = 2'(m_snoozes);
        cnt = (m_mode == 1) ? 9'(m_elapsed) : (m_mode == 2) ? 9'(m_remain) : 9'd0;
        bz  = (m_mode == 1) && (m_elapsed % 2 == 0);
        return {st, sc, cnt, bz};
    endfunction

    // Driver: apply one cycle of inputs, advance the model, compare after the edge.
    task automatic drive(input logic s, input logic p, input logic t);
        logic [13:0] e;
        alarmon = on_v; buzz_in = buzz_v; snooze = s; stop = p; sec_tick = t;
        model_step(on_v, s, p, t, buzz_v);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("state", 32'(state), 32'(e[13:12]));
            check_eq("snooze_cnt", 32'(snooze_cnt), 32'(e[11:10]));
            check_eq("sec_cnt", 32'(sec_cnt), 32'(e[9:1]));
            check_eq("buzzer", 32'(buzzer), 32'(e[0]));
        end
        if (buzzer !== last_buzz) toggles++;
        last_buzz = buzzer;
        snooze = 1'b0; stop = 1'b0; sec_tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ring_start();
        buzz_v = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        buzz_v = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; sec_tick = 1'b0; buzz_in = 1'b0; alarmon = 1'b1;
        snooze = 1'b0; stop = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_buzzer", 32'(buzzer), 32'd0);
        check_eq("rst_sec_cnt", 32'(sec_cnt), 32'd0);
        check_eq("rst_snooze_cnt", 32'(snooze_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Timeout after RING seconds with 59 buzzer toggles.
        ring_start();
        check_eq("to_enter_state", 32'(state), 32'd1);
        check_eq("to_enter_buzzer", 32'(buzzer), 32'd1);
        toggles = 0;
        tick_n(RING);
        check_eq("to_exit_state", 32'(state), 32'd0);
        check_eq("to_exit_buzzer", 32'(buzzer), 32'd0);
        check_eq("to_toggles", 32'(toggles), 32'd59);

        // Snooze cycle.
        ring_start();
        tick_n(5);
        drive(1'b1, 1'b0, 1'b0);
        check_eq("snz_state", 32'(state), 32'd2);
        check_eq("snz_sec_cnt", 32'(sec_cnt), 32'd300);
        check_eq("snz_cnt", 32'(snooze_cnt), 32'd1);
        tick_n(SNZ);
        check_eq("snz_exp_state", 32'(state), 32'd1);
        check_eq("snz_exp_sec_cnt", 32'(sec_cnt), 32'd0);
        check_eq("snz_exp_buzzer", 32'(buzzer), 32'd1);

        // Snooze limit.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick_n(SNZ);
        end
        drive(1'b1, 1'b0, 1'b0);
        check_eq("lim_state", 32'(state), 32'd1);
        check_eq("lim_cnt", 32'(snooze_cnt), 32'd3);
        drive(1'b0, 1'b1, 1'b0);
        check_eq("lim_stop_state", 32'(state), 32'd0);
        check_eq("lim_stop_cnt", 32'(snooze_cnt), 32'd0);

        // Same-cycle priorities.
        ring_start();
        drive(1'b1, 1'b1, 1'b0);
        check_eq("pri_stop_snz", 32'(state), 32'd0);
        ring_start();
        drive(1'b1, 1'b0, 1'b0);
        on_v = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        check_eq("pri_off_snz", 32'(state), 32'd0);
        on_v = 1'b1;
        ring_start();
        tick_n(RING - 1);
        drive(1'b1, 1'b0, 1'b1);
        check_eq("pri_snz_timeout", 32'(state), 32'd2);
        drive(1'b0, 1'b1, 1'b0);

        // Held match level does not re-ring.
        ring_start();
        drive(1'b0, 1'b1, 1'b0);
        tick_n(RING);
        check_eq("held_no_ring", 32'(state), 32'd0);
        ring_start();
        check_eq("held_rering", 32'(state), 32'd1);

        // Reset mid-snooze clears outputs before any clock edge.
        drive(1'b1, 1'b0, 1'b0);
        tick_n(150);
        check_eq("abort_pre_cnt", 32'(sec_cnt), 32'd150);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_buzzer", 32'(buzzer), 32'd0);
        check_eq("abort_sec_cnt", 32'(sec_cnt), 32'd0);
        check_eq("abort_snooze_cnt", 32'(snooze_cnt), 32'd0);
        exp_q.delete();
        model_reset();
        buzz_v = 1'b1; buzz_in = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        check_eq("rst_release_edge", 32'(state), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            on_v = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) buzz_v = ~buzz_v;
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
